// File: rtl/rhd_spi_chip_model.sv
// Chip-side responder for one RHD2164 MISO lane.
// Decodes 16-bit SPI command frames, keeps a small register file, returns
// results with the chip's two-frame pipeline delay and produces deterministic
// CONVERT data for loopback self-test of the acquisition path.
module rhd_spi_chip_model #(
    parameter int          STARTING_SEED = 0,
    parameter int          CHANNELS      = 32,
    parameter logic [7:0]  MISO_MARKER   = 8'h35
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCLK,
    input  logic       MOSI,
    input  logic       CS,
    output logic       MISO,
    output logic [5:0] channel_out,
    output logic       convert_strobe,
    output logic       reg_wr_strobe,
    output logic [5:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic       frame_error
);

    typedef enum logic {S_IDLE, S_FRAME} state_t;

    state_t      state, state_nxt;
    logic [1:0]  sclk_s, mosi_s, cs_s;
    logic        sclk_d, cs_d;
    logic [15:0] rx;
    logic [4:0]  bit_cnt;
    logic [15:0] miso_sr;
    logic [15:0] tx_word, pend;
    logic [15:0] sample_idx;
    logic [7:0]  regs [0:21];

    logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic        frame_start, frame_close, shift_en, miso_adv;
    logic [5:0]  r_addr;
    logic [7:0]  rd_val;
    logic [15:0] result;

    // Two-flop synchronizers plus one delayed copy for edge detection.
    // CS resets low so a CS already low at reset release is not taken as a
    // fresh fall; the resulting rise seen in idle is harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s <= 2'b00;
            mosi_s <= 2'b00;
            cs_s   <= 2'b00;
            sclk_d <= 1'b0;
            cs_d   <= 1'b0;
        end else begin
            sclk_s <= {sclk_s[0], SCLK};
            mosi_s <= {mosi_s[0], MOSI};
            cs_s   <= {cs_s[0], CS};
            sclk_d <= sclk_s[1];
            cs_d   <= cs_s[1];
        end
    end

    assign sclk_rise = sclk_s[1] & ~sclk_d;
    assign sclk_fall = ~sclk_s[1] & sclk_d;
    assign cs_rise   = cs_s[1] & ~cs_d;
    assign cs_fall   = ~cs_s[1] & cs_d;

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Frame opens on CS fall and closes on CS rise.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cs_fall) state_nxt = S_FRAME;
            S_FRAME: if (cs_rise) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Frame control; a CS rise wins over a same-cycle SCLK edge.
    always_comb begin
        frame_start = (state == S_IDLE) && cs_fall;
        frame_close = (state == S_FRAME) && cs_rise;
        shift_en    = (state == S_FRAME) && !cs_rise && sclk_rise;
        miso_adv    = (state == S_FRAME) && !cs_rise && sclk_fall;
        MISO        = (state == S_FRAME) && miso_sr[15];
    end

    // Receive shifter, saturating bit counter and MISO shifter (zeros fill
    // in behind the word, so MISO is 0 after the 16th bit).
    always_ff @(posedge clk) begin
        if (rst) begin
            rx      <= 16'h0000;
            bit_cnt <= 5'd0;
            miso_sr <= 16'h0000;
        end else if (frame_start) begin
            rx      <= 16'h0000;
            bit_cnt <= 5'd0;
            miso_sr <= tx_word;
        end else begin
            if (shift_en) begin
                rx      <= {rx[14:0], mosi_s[1]};
                bit_cnt <= (bit_cnt == 5'd31) ? bit_cnt : bit_cnt + 5'd1;
            end
            if (miso_adv)
                miso_sr <= {miso_sr[14:0], 1'b0};
        end
    end

    assign r_addr = rx[13:8];

    // READ value lookup: writable bank, ID string and fixed chip constants.
    always_comb begin
        rd_val = 8'h00;
        if (r_addr <= 6'd21) begin
            rd_val = regs[r_addr[4:0]];
        end else begin
            case (r_addr)
                6'd40:   rd_val = 8'h49;
                6'd41:   rd_val = 8'h4E;
                6'd42:   rd_val = 8'h54;
                6'd43:   rd_val = 8'h41;
                6'd44:   rd_val = 8'h4E;
                6'd59:   rd_val = MISO_MARKER;
                6'd62:   rd_val = 8'd64;
                6'd63:   rd_val = 8'd4;
                default: rd_val = 8'h00;
            endcase
        end
    end

    // Response word for the frame just received.
    always_comb begin
        result = 16'h0000;
        case (rx[15:14])
            2'b00: if (int'(r_addr) < CHANNELS)
                       result = 16'(STARTING_SEED) + {10'd0, r_addr} + sample_idx;
            2'b10: result = {8'hFF, rx[7:0]};
            2'b11: result = {8'h00, rd_val};
            default: result = 16'h0000;
        endcase
    end

    // Commit a closed frame: advance the pipeline, apply side effects, strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_word        <= 16'h0000;
            pend           <= 16'h0000;
            sample_idx     <= 16'h0000;
            channel_out    <= 6'd0;
            convert_strobe <= 1'b0;
            reg_wr_strobe  <= 1'b0;
            reg_wr_addr    <= 6'd0;
            reg_wr_data    <= 8'h00;
            frame_error    <= 1'b0;
            for (int i = 0; i < 22; i++) regs[i] <= 8'h00;
        end else begin
            convert_strobe <= 1'b0;
            reg_wr_strobe  <= 1'b0;
            if (frame_close) begin
                if (bit_cnt == 5'd16) begin
                    tx_word <= pend;
                    pend    <= result;
                    case (rx[15:14])
                        2'b00: begin
                            channel_out    <= r_addr;
                            convert_strobe <= 1'b1;
                            if (r_addr == 6'd0) sample_idx <= sample_idx + 16'd1;
                        end
                        2'b01: if (rx == 16'h6A00) sample_idx <= 16'h0000;
                        2'b10: if (r_addr <= 6'd21) begin
                            regs[r_addr[4:0]] <= rx[7:0];
                            reg_wr_strobe     <= 1'b1;
                            reg_wr_addr       <= r_addr;
                            reg_wr_data       <= rx[7:0];
                        end
                        default: ;
                    endcase
                end else begin
                    frame_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rhd_spi_chip_model.sv
// Bench for rhd_spi_chip_model: fixed vector table, sweeps, corner sequences
// and random frames checked against a command-level model of the chip.
module tb_rhd_spi_chip_model;

    localparam int SEED = 144;
    localparam int CHN  = 32;
    localparam logic [7:0] MARK = 8'h35;
    localparam int HP   = 80;   // SCLK half period, 8 clk

    logic       clk = 1'b0;
    logic       rst, SCLK, MOSI, CS;
    logic       MISO, convert_strobe, reg_wr_strobe, frame_error;
    logic [5:0] channel_out, reg_wr_addr;
    logic [7:0] reg_wr_data;

    int checks = 0;
    int errors = 0;

    // Strobe monitor.
    int         wr_cnt = 0, conv_cnt = 0;
    logic [5:0] last_addr = 6'd0;
    logic [7:0] last_data = 8'h00;

    // Reference model state.
    logic [7:0]  m_regs [0:21];
    logic [15:0] m_pend, m_tx, m_idx;
    logic        m_err;
    logic [5:0]  m_chan;
    int          m_wr_cnt = 0, m_conv_cnt = 0;

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [9];

    rhd_spi_chip_model #(.STARTING_SEED(SEED), .CHANNELS(CHN), .MISO_MARKER(MARK)) dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .MOSI(MOSI), .CS(CS), .MISO(MISO),
        .channel_out(channel_out), .convert_strobe(convert_strobe),
        .reg_wr_strobe(reg_wr_strobe), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wr_strobe) begin
            wr_cnt++;
            last_addr = reg_wr_addr;
            last_data = reg_wr_data;
        end
        if (convert_strobe) conv_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 22; i++) m_regs[i] = 8'h00;
        m_pend = 0; m_tx = 0; m_idx = 0; m_err = 0; m_chan = 0;
    endfunction

    function automatic logic [7:0] model_read(input int r);
        if (r <= 21) return m_regs[r];
        case (r)
            40: return "I";
            41: return "N";
            42: return "T";
            43: return "A";
            44: return "N";
            59: return MARK;
            62: return 8'd64;
            63: return 8'd4;
            default: return 8'h00;
        endcase
    endfunction

    // Command-level chip behaviour for one closed frame.
    function automatic void model_frame(input logic [15:0] cmd, input int nbits);
        int r, d;
        logic [15:0] res;
        if (nbits != 16) begin
            m_err = 1'b1;
            return;
        end
        r = int'(cmd[13:8]);
        d = int'(cmd[7:0]);
        res = 16'h0000;
        if (cmd[15:14] == 2'b00) begin
            if (r < CHN) res = 16'((SEED + r + int'(m_idx)) % 65536);
            m_chan = cmd[13:8];
            m_conv_cnt++;
            if (r == 0) m_idx = m_idx + 16'd1;
        end else if (cmd[15:14] == 2'b10) begin
            res = 16'hFF00 + 16'(d);
            if (r <= 21) begin
                m_regs[r] = 8'(d);
                m_wr_cnt++;
            end
        end else if (cmd[15:14] == 2'b11) begin
            res = {8'h00, model_read(r)};
        end else if (cmd == 16'h6A00) begin
            m_idx = 0;
        end
        m_tx   = m_pend;
        m_pend = res;
    endfunction

    // Drive one SPI frame of nbits, sampling MISO just before each SCLK rise.
    task automatic run_frame(input logic [15:0] cmd, input int nbits, output logic [15:0] rsp);
        rsp = 16'h0000;
        CS = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 16) ? cmd[15-i] : 1'($urandom % 2);
            #HP;
            if (i < 16) rsp[15-i] = MISO;
            SCLK = 1'b1;
            #HP;
            SCLK = 1'b0;
        end
        #HP;
        CS = 1'b1;
        MOSI = 1'b0;
        #(3*HP);
    endtask

    // Frame plus model step; returns the DUT word and the model's expectation.
    task automatic do_frame(input logic [15:0] cmd, input int nbits,
                            output logic [15:0] rsp, output logic [15:0] exp);
        exp = m_tx;
        run_frame(cmd, nbits, rsp);
        model_frame(cmd, nbits);
    endtask

    initial begin
        logic [15:0] rsp, exp, cmd;
        int nb, k;

        rst = 1'b1; SCLK = 1'b0; MOSI = 1'b0; CS = 1'b1;
        model_reset();
        #48;
        check("rst_miso", MISO, 0);
        check("rst_chan", channel_out, 0);
        check("rst_strobes", {convert_strobe, reg_wr_strobe}, 0);
        check("rst_wr_addr_data", {reg_wr_addr, reg_wr_data}, 0);
        check("rst_frame_error", frame_error, 0);
        #5 rst = 1'b0;
        #200;

        // ID reads, then WRITE/READ of register 5.
        tbl[0] = '{16'hE800, 16'h0000};
        tbl[1] = '{16'hE900, 16'h0000};
        tbl[2] = '{16'hFF00, 16'h0049};
        tbl[3] = '{16'hFF00, 16'h004E};
        tbl[4] = '{16'hFF00, 16'h0004};
        tbl[5] = '{16'h85A7, 16'h0004};
        tbl[6] = '{16'hC500, 16'h0004};
        tbl[7] = '{16'hFF00, 16'hFFA7};
        tbl[8] = '{16'hFF00, 16'h00A7};
        for (int i = 0; i < 9; i++) begin
            do_frame(tbl[i].cmd, 16, rsp, exp);
            check($sformatf("tbl%0d_miso", i), rsp, tbl[i].exp);
        end
        check("wr_cnt_once", wr_cnt, 1);
        check("wr_addr_data", {last_addr, last_data}, {6'd5, 8'hA7});

        // Two CONVERT sweeps over all channels.
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 32; c++) begin
                cmd = {2'b00, 6'(c), 8'h00};
                do_frame(cmd, 16, rsp, exp);
                check($sformatf("sweep%0d_ch%0d", s, c), rsp, exp);
                check($sformatf("sweep%0d_chan_out%0d", s, c), channel_out, c);
            end
        check("conv_cnt", conv_cnt, m_conv_cnt);

        // Out-of-range CONVERT channel.
        do_frame(16'h2800, 16, rsp, exp);
        check("conv40_chan_out", channel_out, 40);
        do_frame(16'hFF00, 16, rsp, exp);
        do_frame(16'hFF00, 16, rsp, exp);
        check("conv40_result", rsp, 16'h0000);

        // Short frame must not disturb the pipeline.
        do_frame(16'hFF00, 15, rsp, exp);
        check("short_frame_error", frame_error, 1);
        do_frame(16'hFF00, 16, rsp, exp);
        check("after_short_1", rsp, exp);
        do_frame(16'hFF00, 16, rsp, exp);
        check("after_short_2", rsp, exp);
        do_frame(16'hFF00, 16, rsp, exp);
        check("after_short_read63", rsp, 16'h0004);

        // Random frames against the model.
        for (int i = 0; i < 50; i++) begin
            k = $urandom_range(0, 9);
            nb = 16;
            case (k)
                0, 1, 2: cmd = {2'b00, 6'($urandom_range(0, 45)), 8'($urandom)};
                3, 8:    cmd = {2'b10, 6'($urandom_range(0, 30)), 8'($urandom)};
                4, 5:    cmd = {2'b11, 6'($urandom_range(0, 63)), 8'($urandom)};
                6:       cmd = ($urandom % 2) ? 16'h5500 : 16'h6A00;
                7:       cmd = {2'b01, 14'($urandom)};
                default: begin
                    cmd = 16'($urandom);
                    nb  = ($urandom % 2) ? $urandom_range(8, 15) : $urandom_range(17, 20);
                end
            endcase
            do_frame(cmd, nb, rsp, exp);
            if (nb == 16) check($sformatf("rand%0d_miso", i), rsp, exp);
        end
        check("rand_chan_out", channel_out, m_chan);
        check("rand_frame_error", frame_error, m_err);
        check("rand_wr_cnt", wr_cnt, m_wr_cnt);
        check("rand_conv_cnt", conv_cnt, m_conv_cnt);

        // Reset in the middle of WRITE(3,0x11).
        k = wr_cnt;
        cmd = 16'h8311;
        CS = 1'b0;
        for (int i = 0; i < 8; i++) begin
            MOSI = cmd[15-i];
            #HP; SCLK = 1'b1; #HP; SCLK = 1'b0;
        end
        #40 rst = 1'b1;
        #50;
        check("midrst_miso", MISO, 0);
        #40 rst = 1'b0;
        model_reset();
        #40 CS = 1'b1;
        MOSI = 1'b0;
        #(3*HP);
        check("midrst_frame_error", frame_error, 0);
        check("midrst_no_write", wr_cnt, k);
        for (int i = 0; i < 3; i++) begin
            do_frame(16'hC300, 16, rsp, exp);
            check($sformatf("midrst_read3_%0d", i), rsp, 16'h0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
